gf256_adder: RTL and testbench
==============================

Name: gf256_adder

Overview:
- Registered GF(2^8) adder (bitwise XOR) for the AES datapath, used by AddRoundKey and MixColumns term summation.
- Processes LANES independent byte lanes per cycle.
- Optional accumulate mode XORs new operands into the previous result, so multi-term sums need no external XOR tree.
- One clock domain; result is registered with a valid flag.

Parameters:
- LANES, 1, number of independent 8-bit GF(2^8) lanes; bus widths are 8*LANES. Legal range 1..16; 16 covers a full 128-bit AES state.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid this cycle
- acc_en  input  1  accumulate: include the current out in the sum
- in1  input  8*LANES  operand A, lane k = bits [8k+7:8k]
- in2  input  8*LANES  operand B, same lane packing
- out  output  8*LANES  registered GF(2^8) sum
- out_valid  output  1  out was updated on the previous clock edge

Behaviour:
- Lane sum: sum_k = in1_k XOR in2_k. No carries and no reduction polynomial are needed, because GF(2^8) addition is pure XOR.
- Accumulate: if acc_en=1, sum_k = in1_k XOR in2_k XOR out_k, where out_k is the current registered value.
- Priority at each rising clk edge:
  - rst=1: out <= 0 and out_valid <= 0. Reset overrides in_valid and acc_en.
  - else if in_valid=1: out <= sum and out_valid <= 1.
  - else: out holds its value and out_valid <= 0.
- Latency is exactly 1 cycle. Throughput is one operation per cycle; back-to-back in_valid is allowed.
- acc_en is ignored when in_valid=0.
- acc_en=1 on the first operation after reset accumulates into 0.
- No backpressure: the consumer must sample out while out_valid=1. After that, out holds until the next in_valid.
- Lanes are fully independent, with no cross-lane interaction.
- Algebraic identities required:
  - x XOR 0 = x
  - x XOR x = 0
  - the operation is commutative (swapping in1/in2 gives an identical out)
- Operands containing X/Z are not supported. The output must be exactly 0/1 for all-known inputs.

Optional Feature:
- Macro: GF_ADDER_PARITY_EN.
- Defined: adds an output port out_par [LANES-1:0], where out_par[k] is the XOR-reduction of out lane k.
  - Registered together with out, same timing.
  - Reset to 0; holds when in_valid=0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (aes_pkg): constants GF_BYTE_W=8 and AES_STATE_LANES=16.
- One natural sub-module, gf256_add_lane: combinational 8-bit XOR of a, b and an optional accumulator term.
  - Instantiated LANES times via generate.
  - The top level owns the registers and valid logic.

Test Plan:
- Reset: hold rst=1 with in_valid=1, in1=in2=8'hFF -> out=8'h00 and out_valid=0 after the edge. Release rst -> out_valid stays 0 until in_valid is asserted.
- Basic vectors, LANES=1, one per cycle, in_valid=1:
  - 00^00 -> 00
  - FF^00 -> FF
  - 00^FF -> FF
  - FF^FF -> 00
  - Each result appears exactly one cycle later with out_valid=1.
- Hold: after 57^83 -> D4, drive in_valid=0 for 3 cycles -> out stays D4 and out_valid=0.
- Accumulate:
  - 57^83 -> D4
  - next cycle acc_en=1, in1=0x13, in2=0x00 -> C7
  - next cycle acc_en=1, in1=0xC7, in2=0x00 -> 00
- Multi-lane (LANES=16): in1=128'h00112233445566778899AABBCCDDEEFF, in2=128'h000102030405060708090A0B0C0D0E0F -> out=128'h00102030405060708090A0B0C0D0E0F0 after 1 cycle.
- Parity (GF_ADDER_PARITY_EN): FF^00 -> out_par=0. 01^00 -> out_par=1. Reset -> out_par=0.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath constants
package aes_pkg;
    localparam int GF_BYTE_W       = 8;
    localparam int AES_STATE_LANES = 16;
endpackage

// File: rtl/gf256_add_lane.sv
// rtl/gf256_add_lane.sv - combinational GF(2^8) byte add with optional accumulator term
module gf256_add_lane
    import aes_pkg::*;
(
    input  logic [GF_BYTE_W-1:0] a,
    input  logic [GF_BYTE_W-1:0] b,
    input  logic [GF_BYTE_W-1:0] acc,
    input  logic                 acc_en,
    output logic [GF_BYTE_W-1:0] sum
);
    always_comb begin
        sum = a ^ b ^ (acc_en ? acc : '0);
    end
endmodule

// File: rtl/gf256_adder.sv
// rtl/gf256_adder.sv - registered multi-lane GF(2^8) adder; GF_ADDER_PARITY_EN adds per-lane parity output
module gf256_adder
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       acc_en,
    input  logic [GF_BYTE_W*LANES-1:0] in1,
    input  logic [GF_BYTE_W*LANES-1:0] in2,
    output logic [GF_BYTE_W*LANES-1:0] out,
`ifdef GF_ADDER_PARITY_EN
    output logic [LANES-1:0]           out_par,
`endif
    output logic                       out_valid
);
    logic [GF_BYTE_W*LANES-1:0] sum;

    // The accumulator term is the registered out, so multi-term sums chain cycle by cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gf256_add_lane u_lane (
            .a      (in1[k*GF_BYTE_W +: GF_BYTE_W]),
            .b      (in2[k*GF_BYTE_W +: GF_BYTE_W]),
            .acc    (out[k*GF_BYTE_W +: GF_BYTE_W]),
            .acc_en (acc_en),
            .sum    (sum[k*GF_BYTE_W +: GF_BYTE_W])
        );
    end

`ifdef GF_ADDER_PARITY_EN
    logic [LANES-1:0] par_next;

    always_comb begin
        par_next = '0;
        for (int k = 0; k < LANES; k++) begin
            par_next[k] = ^sum[k*GF_BYTE_W +: GF_BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_par <= '0;
        end else if (in_valid) begin
            out_par <= par_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            out       <= sum;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gf256_adder.sv
// tb/tb_gf256_adder.sv - randomized bench for gf256_adder with LANES=16 against a vector-level XOR model
module tb_gf256_adder;
    localparam int LANES = 16;
    localparam int W     = 8 * LANES;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             acc_en;
    logic [W-1:0]     in1;
    logic [W-1:0]     in2;
    logic [W-1:0]     out;
    logic             out_valid;
`ifdef GF_ADDER_PARITY_EN
    logic [LANES-1:0] out_par;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_out;
    logic         m_valid;
    logic [W-1:0] saved;

    gf256_adder #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .acc_en    (acc_en),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
`ifdef GF_ADDER_PARITY_EN
        .out_par   (out_par),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES-1:0] lane_parity(input logic [W-1:0] v);
        logic [LANES-1:0] p;
        for (int k = 0; k < LANES; k++) begin
            int ones = 0;
            for (int b = 0; b < 8; b++) ones += int'(v[8*k+b]);
            p[k] = ones % 2 == 1;
        end
        return p;
    endfunction

    // Apply one cycle of inputs, advance the model, then compare just after the edge.
    task automatic cycle(input string tag, input logic r, input logic v, input logic a,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        rst = r; in_valid = v; acc_en = a; in1 = x; in2 = y;
        @(posedge clk);
        if (r) begin
            m_out = '0; m_valid = 1'b0;
        end else if (v) begin
            m_out = a ? (m_out ^ x ^ y) : (x ^ y);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, ".out"}, out, m_out);
        check({tag, ".valid"}, W'(out_valid), W'(m_valid));
`ifdef GF_ADDER_PARITY_EN
        check({tag, ".par"}, W'(out_par), W'(lane_parity(m_out)));
`endif
    endtask

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [W-1:0] a, b, ones;
        ones = '1;
        rst = 1'b1; in_valid = 1'b1; acc_en = 1'b1; in1 = ones; in2 = ones;
        m_out = '0; m_valid = 1'b0;

        cycle("reset", 1'b1, 1'b1, 1'b1, ones, ones);
        check("reset_out_const", out, '0);
        cycle("idle0", 1'b0, 1'b0, 1'b0, ones, '0);
        cycle("idle1", 1'b0, 1'b0, 1'b1, ones, ones);

        cycle("v00_00", 1'b0, 1'b1, 1'b0, W'(8'h00), W'(8'h00));
        cycle("vff_00", 1'b0, 1'b1, 1'b0, W'(8'hFF), W'(8'h00));
        check("vff_00_const", out, W'(8'hFF));
        cycle("v00_ff", 1'b0, 1'b1, 1'b0, W'(8'h00), W'(8'hFF));
        cycle("vff_ff", 1'b0, 1'b1, 1'b0, W'(8'hFF), W'(8'hFF));
        check("vff_ff_const", out, '0);

        cycle("v57_83", 1'b0, 1'b1, 1'b0, W'(8'h57), W'(8'h83));
        check("v57_83_const", out, W'(8'hD4));
        for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'b0, 1'b0, rnd_vec(), rnd_vec());
        check("hold_const", out, W'(8'hD4));

        cycle("acc_base", 1'b0, 1'b1, 1'b0, W'(8'h57), W'(8'h83));
        cycle("acc_13", 1'b0, 1'b1, 1'b1, W'(8'h13), W'(8'h00));
        check("acc_13_const", out, W'(8'hC7));
        cycle("acc_c7", 1'b0, 1'b1, 1'b1, W'(8'hC7), W'(8'h00));
        check("acc_c7_const", out, '0);

        cycle("multilane", 1'b0, 1'b1, 1'b0,
              128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F);
        check("multilane_const", out, 128'h00102030405060708090A0B0C0D0E0F0);

        cycle("par_01", 1'b0, 1'b1, 1'b0, W'(8'h01), W'(8'h00));
        cycle("rst_again", 1'b1, 1'b0, 1'b0, '0, '0);
        cycle("acc_after_rst", 1'b0, 1'b1, 1'b1, W'(8'h3C), W'(8'h05));
        check("acc_after_rst_const", out, W'(8'h39));

        a = rnd_vec(); b = rnd_vec();
        cycle("comm_ab", 1'b0, 1'b1, 1'b0, a, b);
        saved = out;
        cycle("comm_ba", 1'b0, 1'b1, 1'b0, b, a);
        check("commutative", out, saved);
        cycle("self_xor", 1'b0, 1'b1, 1'b0, a, a);
        cycle("zero_id", 1'b0, 1'b1, 1'b0, a, '0);

        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                  1'($urandom), rnd_vec(), rnd_vec());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
